safe_reset_sequencer: RTL and testbench
=======================================

# safe_reset_sequencer

Staged reset generator for the safety island: drives the ordered reset deassertion of NUM_STAGES safety-domain sub-blocks, waits for each stage's out-of-reset acknowledge before releasing the next, and re-enters reset on software, fault or clock-loss requests. It sits upstream of the per-domain reset synchronizers and monitors, producing the reset those blocks consume. It also reports timeouts and causes through C001_xxxx error codes.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs (2..8)
- HOLD_CYCLES, 128, minimum all-asserted duration with clock stable (must exceed 100 so downstream reset monitors see a stable reset)
- ACK_TIMEOUT, 1024, max cycles to wait for a stage acknowledge
- CNT_W, 16, width of the shared timer; must hold max(HOLD_CYCLES, ACK_TIMEOUT)
- clk_safety_i  in  1  safety-domain clock
- rst_n_safety_i  in  1  reset, synchronous, active-low
- clk_stable_i  in  1  safety clock qualified stable (level)
- sw_rst_req_i  in  1  software warm-reset request (single-cycle pulse)
- fault_rst_req_i  in  1  fatal-fault reset request (level or pulse)
- stage_ack_i  in  NUM_STAGES  per-stage "out of reset" acknowledge (level)
- stage_rst_n_o  out  NUM_STAGES  per-stage active-low reset, registered
- seq_busy_o  out  1  sequence in progress (any state except RUN)
- seq_done_o  out  1  all stages released and acknowledged
- rst_cause_o  out  2  cause of last reset entry
- error_o  out  1  sticky error flag
- error_code_o  out  32  code of first error since reset

## Operation
- States: ASSERT, RELEASE_WAIT (stage index k), RUN, ERROR.
- Reset (rst_n_safety_i=0 at a clock edge): state ASSERT, k=0, timer=0, stage_rst_n_o all 0, seq_busy_o=1, seq_done_o=0, rst_cause_o=POR, error_o=0, error_code_o=0.
- ASSERT: all stages low. Timer increments each cycle clk_stable_i=1; clk_stable_i=0 clears timer. When timer reaches HOLD_CYCLES-1 with clk_stable_i=1: stage_rst_n_o[0]=1, k=0, timer=0, go RELEASE_WAIT.
- RELEASE_WAIT: stages 0..k high, rest low. stage_ack_i[k]=1: if k<NUM_STAGES-1, release stage k+1, k++, timer=0; else go RUN. Timer reaching ACK_TIMEOUT-1 without ack -> ERROR.
- RUN: all high, seq_done_o=1, seq_busy_o=0.
- Re-entry to ASSERT (all stages low next cycle, timer=0, k=0) from RUN or RELEASE_WAIT; priority fault_rst_req_i > clock loss (clk_stable_i=0) > sw_rst_req_i. Sets rst_cause_o = FAULT / CLK_LOSS / SW.
- sw_rst_req_i is ignored while in ASSERT; honoured in RELEASE_WAIT and RUN.
- Clock loss during RELEASE_WAIT also returns to ASSERT.
- ERROR: all stages low, seq_busy_o=1. sw_rst_req_i or fault_rst_req_i -> ASSERT (retry). Otherwise stay.
- Errors: first error since reset latches error_code_o; error_o sticky until rst_n_safety_i. Codes: clock loss in RUN/RELEASE_WAIT 32'hC001_0001; ack timeout stage k 32'hC001_0010+k; fault request 32'hC001_0020. SW reset is not an error.

## Timing
- All outputs registered; request sampled in cycle t -> stage_rst_n_o low at t+1.
- POR with clk_stable_i=1 from first cycle after reset release: stage_rst_n_o[0] rises exactly HOLD_CYCLES cycles after entering ASSERT.
- stage_ack_i[k]=1 sampled at t -> stage_rst_n_o[k+1] high at t+1 (or seq_done_o high at t+1 for last stage).
- Ack timeout: release at t, no ack through t+ACK_TIMEOUT-1 -> ERROR, all stages low at t+ACK_TIMEOUT.
- Ack arriving on the same cycle as the timeout terminal count wins (no error).
- Acks for stages >k ignored; ack deasserting after release is ignored.

## Structure
- Package safe_reset_pkg: state enum, rst_cause enum (POR=0, SW=1, FAULT=2, CLK_LOSS=3), error code constants.
- Single module, one shared CNT_W timer; no sub-module.

## Test plan
- POR, clk_stable_i=1, acks returned 2 cycles after each release -> stage0 high at cycle 128, stage1 at 131, stage2 at 134, stage3 at 137, seq_done_o at 140, rst_cause_o=0.
- clk_stable_i dropped for 1 cycle at hold cycle 50 -> hold restarts; stage0 releases 128 cycles after clk_stable_i returns.
- Stage2 ack never asserted -> all stages low ACK_TIMEOUT cycles after stage2 release, error_o=1, error_code_o=32'hC001_0012; sw_rst_req_i then restarts sequence, error_o stays 1.
- RUN, sw_rst_req_i pulse -> all stages low next cycle, rst_cause_o=1, error_o=0, full resequence.
- RUN, fault_rst_req_i and clk_stable_i=0 same cycle -> rst_cause_o=2, error_code_o=32'hC001_0020.
- rst_n_safety_i asserted mid RELEASE_WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/safe_reset_pkg.sv
// Shared types and error codes for the safety-island staged reset sequencer.
package safe_reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT       = 2'd0,
        ST_RELEASE_WAIT = 2'd1,
        ST_RUN          = 2'd2,
        ST_ERROR        = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR      = 2'd0,
        CAUSE_SW       = 2'd1,
        CAUSE_FAULT    = 2'd2,
        CAUSE_CLK_LOSS = 2'd3
    } rst_cause_e;

    localparam logic [31:0] ERR_NONE        = 32'h0000_0000;
    localparam logic [31:0] ERR_CLK_LOSS    = 32'hC001_0001;
    localparam logic [31:0] ERR_ACK_TIMEOUT = 32'hC001_0010;
    localparam logic [31:0] ERR_FAULT       = 32'hC001_0020;

    // Ack-timeout code carries the index of the stage that never acknowledged.
    function automatic logic [31:0] ack_timeout_code(input logic [2:0] stage);
        return ERR_ACK_TIMEOUT + {29'd0, stage};
    endfunction

endpackage

// File: rtl/safe_reset_sequencer.sv
// Staged reset generator: holds all safety-domain stages in reset, then
// releases them one at a time, waiting for each stage's acknowledge.
//
// state           | meaning
// ----------------+----------------------------------------------------------
// ST_ASSERT       | all stages low, counting stable-clock hold time
// ST_RELEASE_WAIT | stages 0..k high, waiting for stage_ack_i[k]
// ST_RUN          | all stages high and acknowledged, sequence done
// ST_ERROR        | ack timeout, all stages low until sw/fault retry
module safe_reset_sequencer
    import safe_reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 128,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk_safety_i,
    input  logic                  rst_n_safety_i,
    input  logic                  clk_stable_i,
    input  logic                  sw_rst_req_i,
    input  logic                  fault_rst_req_i,
    input  logic [NUM_STAGES-1:0] stage_ack_i,
    output logic [NUM_STAGES-1:0] stage_rst_n_o,
    output logic                  seq_busy_o,
    output logic                  seq_done_o,
    output logic [1:0]            rst_cause_o,
    output logic                  error_o,
    output logic [31:0]           error_code_o
);

    localparam int unsigned K_W = $clog2(NUM_STAGES);

    seq_state_e            state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    rst_cause_e            cause_q, cause_d;
    logic                  err_q, err_d;
    logic [31:0]           code_q, code_d;

    logic                  enter_assert;
    rst_cause_e            enter_cause;
    logic                  raise;
    logic [31:0]           raise_code;

    // Registered state; every output comes straight from a flop.
    always_ff @(posedge clk_safety_i) begin
        if (!rst_n_safety_i) begin
            state_q <= ST_ASSERT;
            k_q     <= '0;
            timer_q <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            timer_q <= timer_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cause_q <= cause_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state, stage release and error capture.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        timer_d      = timer_q;
        stage_d      = stage_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cause_d      = cause_q;
        err_d        = err_q;
        code_d       = code_q;
        enter_assert = 1'b0;
        enter_cause  = cause_q;
        raise        = 1'b0;
        raise_code   = ERR_NONE;

        case (state_q)
            ST_ASSERT: begin
                stage_d = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                // A persisting fault request keeps the hold window from completing.
                if (!clk_stable_i || fault_rst_req_i) begin
                    timer_d = '0;
                end else if (timer_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RELEASE_WAIT;
                    stage_d = {{(NUM_STAGES-1){1'b0}}, 1'b1};
                    k_d     = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_RELEASE_WAIT, ST_RUN: begin
                if (fault_rst_req_i) begin
                    enter_assert = 1'b1;
                    enter_cause  = CAUSE_FAULT;
                    raise        = 1'b1;
                    raise_code   = ERR_FAULT;
                end else if (!clk_stable_i) begin
                    enter_assert = 1'b1;
                    enter_cause  = CAUSE_CLK_LOSS;
                    raise        = 1'b1;
                    raise_code   = ERR_CLK_LOSS;
                end else if (sw_rst_req_i) begin
                    enter_assert = 1'b1;
                    enter_cause  = CAUSE_SW;
                end else if (state_q == ST_RELEASE_WAIT) begin
                    // Ack is checked before the terminal count so a last-cycle ack wins.
                    if (stage_ack_i[k_q]) begin
                        if (k_q == K_W'(NUM_STAGES - 1)) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = {stage_q[NUM_STAGES-2:0], 1'b1};
                            k_d     = k_q + K_W'(1);
                            timer_d = '0;
                        end
                    end else if (timer_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_d    = ST_ERROR;
                        stage_d    = '0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        raise      = 1'b1;
                        raise_code = ack_timeout_code(3'(k_q));
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end

            ST_ERROR: begin
                stage_d = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                if (fault_rst_req_i) begin
                    enter_assert = 1'b1;
                    enter_cause  = CAUSE_FAULT;
                    raise        = 1'b1;
                    raise_code   = ERR_FAULT;
                end else if (sw_rst_req_i) begin
                    enter_assert = 1'b1;
                    enter_cause  = CAUSE_SW;
                end
            end

            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (enter_assert) begin
            state_d = ST_ASSERT;
            stage_d = '0;
            timer_d = '0;
            k_d     = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cause_d = enter_cause;
        end

        // Only the first error since reset is recorded.
        if (raise && !err_q) begin
            err_d  = 1'b1;
            code_d = raise_code;
        end
    end

    assign stage_rst_n_o = stage_q;
    assign seq_busy_o    = busy_q;
    assign seq_done_o    = done_q;
    assign rst_cause_o   = cause_q;
    assign error_o       = err_q;
    assign error_code_o  = code_q;

endmodule

// File: tb/tb_safe_reset_sequencer.sv
// Scenario bench for safe_reset_sequencer: expected output snapshots are
// queued with their cycle number and compared when the run reaches them.
module tb_safe_reset_sequencer;

    localparam int NS   = 4;
    localparam int HOLD = 128;
    localparam int ACKT = 1024;

    logic          clk_safety;
    logic          rst_n_safety;
    logic          clk_stable;
    logic          sw_rst_req;
    logic          fault_rst_req;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_rst_n;
    logic          seq_busy;
    logic          seq_done;
    logic [1:0]    rst_cause;
    logic          error_flag;
    logic [31:0]   error_code;

    safe_reset_sequencer #(
        .NUM_STAGES (NS),
        .HOLD_CYCLES(HOLD),
        .ACK_TIMEOUT(ACKT),
        .CNT_W      (16)
    ) dut (
        .clk_safety_i   (clk_safety),
        .rst_n_safety_i (rst_n_safety),
        .clk_stable_i   (clk_stable),
        .sw_rst_req_i   (sw_rst_req),
        .fault_rst_req_i(fault_rst_req),
        .stage_ack_i    (stage_ack),
        .stage_rst_n_o  (stage_rst_n),
        .seq_busy_o     (seq_busy),
        .seq_done_o     (seq_done),
        .rst_cause_o    (rst_cause),
        .error_o        (error_flag),
        .error_code_o   (error_code)
    );

    initial clk_safety = 1'b0;
    always #5 clk_safety = ~clk_safety;

    typedef struct {
        int          cyc;
        logic [40:0] val;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    exp_t  e_cur;
    string n_cur;
    logic [40:0] got;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int rst_cyc   = -1;
    int sw_cyc    = -1;
    int fault_cyc = -1;
    int drop_cyc  = -1;
    int block_stage = -1;
    logic [NS-1:0] ack_force = '0;
    int rel [NS];
    int dly [NS];

    localparam logic [31:0] C_CLK  = 32'hC001_0001;
    localparam logic [31:0] C_FLT  = 32'hC001_0020;
    localparam logic [31:0] C_TO2  = 32'hC001_0012;

    function automatic logic [40:0] snap();
        return {stage_rst_n, seq_done, seq_busy, rst_cause, error_flag, error_code};
    endfunction

    task automatic push(input int c, input string n, input logic [3:0] stg, input logic done,
                        input logic busy, input logic [1:0] cause, input logic err,
                        input logic [31:0] code);
        exp_t e;
        e.cyc = c;
        e.val = {stg, done, busy, cause, err, code};
        sb.push_back(e);
        nm_q.push_back(n);
    endtask

    // One cycle forward; scheduled requests and the ack responder are applied per cycle.
    task automatic advance();
        @(negedge clk_safety);
        cyc++;
        rst_n_safety  = !(cyc == rst_cyc);
        sw_rst_req    = (cyc == sw_cyc);
        fault_rst_req = (cyc == fault_cyc);
        clk_stable    = !(cyc == drop_cyc);
        for (int i = 0; i < NS; i++) begin
            if (!stage_rst_n[i]) rel[i] = -1;
            else if (rel[i] < 0) rel[i] = cyc;
            stage_ack[i] = ((rel[i] >= 0) && (i != block_stage) && (cyc >= rel[i] + dly[i]))
                           || ack_force[i];
        end
    endtask

    task automatic test_reset();
        push(cyc, "reset_vals", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_por_sequence();
        int b;
        b = cyc;
        push(b+127, "por_hold_end", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        push(b+128, "por_stage0",   4'b0001, 0, 1, 2'd0, 0, 32'h0);
        push(b+130, "por_wait_ack0",4'b0001, 0, 1, 2'd0, 0, 32'h0);
        push(b+131, "por_stage1",   4'b0011, 0, 1, 2'd0, 0, 32'h0);
        push(b+134, "por_stage2",   4'b0111, 0, 1, 2'd0, 0, 32'h0);
        push(b+137, "por_stage3",   4'b1111, 0, 1, 2'd0, 0, 32'h0);
        push(b+139, "por_pre_done", 4'b1111, 0, 1, 2'd0, 0, 32'h0);
        push(b+140, "por_done",     4'b1111, 1, 0, 2'd0, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_sw_reset();
        int b;
        b = cyc;
        sw_cyc = b + 1;
        push(b+1,   "sw_still_run",  4'b1111, 1, 0, 2'd0, 0, 32'h0);
        push(b+2,   "sw_all_low",    4'b0000, 0, 1, 2'd1, 0, 32'h0);
        push(b+129, "sw_hold_end",   4'b0000, 0, 1, 2'd1, 0, 32'h0);
        push(b+130, "sw_stage0",     4'b0001, 0, 1, 2'd1, 0, 32'h0);
        push(b+142, "sw_done",       4'b1111, 1, 0, 2'd1, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_fault_clk_loss();
        int b;
        b = cyc;
        fault_cyc = b + 1;
        drop_cyc  = b + 1;
        push(b+2,   "fault_all_low", 4'b0000, 0, 1, 2'd2, 1, C_FLT);
        push(b+130, "fault_stage0",  4'b0001, 0, 1, 2'd2, 1, C_FLT);
        push(b+142, "fault_done",    4'b1111, 1, 0, 2'd2, 1, C_FLT);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_clk_glitch();
        int p;
        rst_cyc = cyc + 1;
        p = cyc + 2;
        drop_cyc = p + 50;
        push(p,     "glitch_por_vals", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        push(p+128, "glitch_no_early", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        push(p+178, "glitch_hold_end", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        push(p+179, "glitch_stage0",   4'b0001, 0, 1, 2'd0, 0, 32'h0);
        push(p+191, "glitch_done",     4'b1111, 1, 0, 2'd0, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_ack_at_terminal();
        int b;
        b = cyc;
        dly[1] = ACKT - 1;
        sw_cyc = b + 1;
        push(b+133,  "term_stage1",   4'b0011, 0, 1, 2'd1, 0, 32'h0);
        push(b+1156, "term_last_cyc", 4'b0011, 0, 1, 2'd1, 0, 32'h0);
        push(b+1157, "term_ack_wins", 4'b0111, 0, 1, 2'd1, 0, 32'h0);
        push(b+1163, "term_done",     4'b1111, 1, 0, 2'd1, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
        dly[1] = 2;
    endtask

    task automatic test_ack_timeout();
        int b;
        int r;
        b = cyc;
        block_stage = 2;
        ack_force   = 4'b1000;
        sw_cyc = b + 1;
        push(b+136,  "to_stage2",     4'b0111, 0, 1, 2'd1, 0, 32'h0);
        push(b+1159, "to_last_wait",  4'b0111, 0, 1, 2'd1, 0, 32'h0);
        push(b+1160, "to_error",      4'b0000, 0, 1, 2'd1, 1, C_TO2);
        push(b+1165, "to_error_hold", 4'b0000, 0, 1, 2'd1, 1, C_TO2);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
        block_stage = -1;
        ack_force   = '0;
        r = cyc;
        sw_cyc = r + 1;
        push(r+2,   "retry_assert", 4'b0000, 0, 1, 2'd1, 1, C_TO2);
        push(r+130, "retry_stage0", 4'b0001, 0, 1, 2'd1, 1, C_TO2);
        push(r+133, "retry_stage1", 4'b0011, 0, 1, 2'd1, 1, C_TO2);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_release();
        int b;
        b = cyc;
        rst_cyc = b + 1;
        push(b+1,   "mid_before_rst", 4'b0011, 0, 1, 2'd1, 1, C_TO2);
        push(b+2,   "mid_reset_vals", 4'b0000, 0, 1, 2'd0, 0, 32'h0);
        push(b+130, "mid_por_stage0", 4'b0001, 0, 1, 2'd0, 0, 32'h0);
        while (sb.size() > 0) begin
            if (sb[0].cyc > cyc) advance();
            else begin
                e_cur = sb.pop_front(); n_cur = nm_q.pop_front(); total++; got = snap();
                if (e_cur.cyc != cyc || got !== e_cur.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d want_cyc=%0d got=%h want=%h", n_cur, cyc, e_cur.cyc, got, e_cur.val);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            rel[i] = -1;
            dly[i] = 2;
        end
        rst_n_safety  = 1'b0;
        clk_stable    = 1'b1;
        sw_rst_req    = 1'b0;
        fault_rst_req = 1'b0;
        stage_ack     = '0;
        repeat (3) @(negedge clk_safety);
        rst_n_safety = 1'b1;
        cyc = 0;

        test_reset();
        test_por_sequence();
        test_sw_reset();
        test_fault_clk_loss();
        test_clk_glitch();
        test_ack_at_terminal();
        test_ack_timeout();
        test_reset_mid_release();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
